// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// instruction-word field positions.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_FETCH  = 2'd1,
    IFU_HOLD   = 2'd2,
    IFU_SQUASH = 2'd3
  } ifu_state_e;

endpackage : ifu_pkg

// File: rtl/ifu_perf_cnt.sv
// Fetch-unit performance counters: completed transfers and discarded fetches.
// Both counters wrap at 16 bits. Only instantiated when IFU_PERF_CNT_EN is set.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_evt,
  input  logic        squash_evt,
  output logic [15:0] fetch_cnt,
  output logic [15:0] squash_cnt
);

  // Free-running event counters, wrap is intentional.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (fetch_evt)  fetch_cnt  <= fetch_cnt + 16'd1;
      if (squash_evt) squash_cnt <= squash_cnt + 16'd1;
    end
  end

endmodule : ifu_perf_cnt

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word at a time from instruction memory,
// holds it for the opcode decoder, and follows redirects from execute.
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt/squash_cnt outputs.
//
// state  | meaning
// IDLE   | first cycle after reset, no request
// FETCH  | request at pc outstanding
// HOLD   | instruction offered to decoder
// SQUASH | redirected while a request was in flight; wait for ack, drop data
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_addr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [4:0]         ir_opcode,
`ifdef IFU_PERF_CNT_EN
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        squash_cnt,
`endif
  output logic [ADDR_W-1:0]  ir_pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  ifu_state_e        state;
  logic [ADDR_W-1:0] pc;
  // Redirect target parked here during SQUASH so imem_addr stays stable.
  logic [ADDR_W-1:0] target;

  assign imem_req  = (state == IFU_FETCH) || (state == IFU_SQUASH);
  assign imem_addr = pc;
  assign ir_valid  = (state == IFU_HOLD) && !redir_valid;
  assign ir_opcode = ir_instr[OPC_MSB:OPC_LSB];

  // Fetch FSM: sequences requests, captures the instruction, applies redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IFU_IDLE;
      pc       <= RESET_PC;
      target   <= RESET_PC;
      ir_instr <= '0;
      ir_pc    <= '0;
    end else begin
      unique case (state)
        IFU_IDLE: begin
          state <= IFU_FETCH;
        end
        IFU_FETCH: begin
          if (imem_ack && !redir_valid) begin
            ir_instr <= imem_rdata;
            ir_pc    <= pc;
            pc       <= pc + PC_ONE;
            state    <= IFU_HOLD;
          end else if (imem_ack && redir_valid) begin
            pc    <= redir_addr;
            state <= IFU_FETCH;
          end else if (redir_valid) begin
            target <= redir_addr;
            state  <= IFU_SQUASH;
          end
        end
        IFU_SQUASH: begin
          // A redirect arriving together with the ack still wins.
          if (imem_ack) begin
            pc    <= redir_valid ? redir_addr : target;
            state <= IFU_FETCH;
          end else if (redir_valid) begin
            target <= redir_addr;
          end
        end
        IFU_HOLD: begin
          if (redir_valid) begin
            pc    <= redir_addr;
            state <= IFU_FETCH;
          end else if (ir_ready) begin
            state <= IFU_FETCH;
          end
        end
        default: begin
          state <= IFU_IDLE;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_evt;
  logic squash_evt;

  assign fetch_evt  = ir_valid && ir_ready;
  assign squash_evt = ((state == IFU_FETCH)  && imem_ack && redir_valid) ||
                      ((state == IFU_SQUASH) && imem_ack) ||
                      ((state == IFU_HOLD)   && redir_valid);

  ifu_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_evt  (fetch_evt),
    .squash_evt (squash_evt),
    .fetch_cnt  (fetch_cnt),
    .squash_cnt (squash_cnt)
  );
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [15:0] redir_addr;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [4:0]  ir_opcode;
  logic [15:0] ir_pc;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int cnt    = 0;
  logic spur = 1'b0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_instr    (ir_instr),
    .ir_opcode   (ir_opcode),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .squash_cnt  (squash_cnt),
`endif
    .ir_pc       (ir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [15:0] a);
    return 32'h2000_0001 | {8'h00, a, 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acks after `lat` request cycles; `spur` injects a stray ack.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (imem_req && rst_n && cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        cnt        = 0;
      end else begin
        imem_ack   = spur;
        imem_rdata = spur ? 32'hDEAD_BEEF : 32'h0;
        if (imem_req) cnt++;
        else          cnt = 0;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    ir_ready    = 1'b0;
    redir_valid = 1'b0;
    redir_addr  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_addr",  {16'd0, imem_addr}, 32'd0);
    check("rst_instr", ir_instr, 32'd0);
    check("rst_irpc",  {16'd0, ir_pc}, 32'd0);

    // zero-wait stream, decoder always ready
    @(negedge clk); rst_n = 1'b1; ir_ready = 1'b1;
    @(negedge clk); #1;
    check("f0_req",  {31'd0, imem_req}, 32'd1);
    check("f0_addr", {16'd0, imem_addr}, 32'd0);
    @(negedge clk); #1;
    check("h0_valid", {31'd0, ir_valid}, 32'd1);
    check("h0_instr", ir_instr, 32'h2000_0001);
    check("h0_opc",   {27'd0, ir_opcode}, 32'd4);
    check("h0_irpc",  {16'd0, ir_pc}, 32'd0);
    check("h0_req",   {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    check("f1_addr", {16'd0, imem_addr}, 32'd1);
    @(negedge clk); #1;
    check("h1_irpc", {16'd0, ir_pc}, 32'd1);
    @(negedge clk); ir_ready = 1'b0; #1;
    check("f2_addr", {16'd0, imem_addr}, 32'd2);

    // stall in HOLD for 5 cycles, one stray ack in the middle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      spur = (i == 2);
      #1;
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
      check("stall_irpc",  {16'd0, ir_pc}, 32'd2);
      check("stall_instr", ir_instr, mem(16'd2));
      check("stall_req",   {31'd0, imem_req}, 32'd0);
      if (i == 4) begin
        ir_ready = 1'b1;
        lat      = 3;
      end
    end

    // redirect while FETCH waits; ack arrives 3 cycles later
    @(negedge clk); redir_valid = 1'b1; redir_addr = 16'h0040; #1;
    check("sq_addr0", {16'd0, imem_addr}, 32'd3);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("sq_addr1", {16'd0, imem_addr}, 32'd3);
    check("sq_req1",  {31'd0, imem_req}, 32'd1);
    @(negedge clk); #1;
    check("sq_addr2", {16'd0, imem_addr}, 32'd3);
    @(negedge clk); #1;
    check("sq_addr3", {16'd0, imem_addr}, 32'd3);
    @(negedge clk); lat = 0; #1;
    check("sq_new_addr",  {16'd0, imem_addr}, 32'h40);
    check("sq_new_req",   {31'd0, imem_req}, 32'd1);
    check("sq_new_valid", {31'd0, ir_valid}, 32'd0);

    // redirect and ready together in HOLD
    @(negedge clk); redir_valid = 1'b1; redir_addr = 16'h0100; #1;
    check("hr_irpc",  {16'd0, ir_pc}, 32'h40);
    check("hr_valid", {31'd0, ir_valid}, 32'd0);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("hr_addr", {16'd0, imem_addr}, 32'h100);
    check("hr_req",  {31'd0, imem_req}, 32'd1);

    // fetch at 0xFFFF, next fetch wraps to 0
    @(negedge clk); redir_valid = 1'b1; redir_addr = 16'hFFFF; #1;
    check("w_irpc_prev", {16'd0, ir_pc}, 32'h100);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("w_addr_ffff", {16'd0, imem_addr}, 32'hFFFF);
    @(negedge clk); #1;
    check("w_irpc",  {16'd0, ir_pc}, 32'hFFFF);
    check("w_instr", ir_instr, 32'h20FF_FF01);
    check("w_valid", {31'd0, ir_valid}, 32'd1);

    // two redirects during SQUASH: latest wins
    @(negedge clk); lat = 2; redir_valid = 1'b1; redir_addr = 16'h0200; #1;
    check("w_addr_0", {16'd0, imem_addr}, 32'd0);
    @(negedge clk); redir_addr = 16'h0300; #1;
    check("lw_addr0", {16'd0, imem_addr}, 32'd0);
    check("lw_req0",  {31'd0, imem_req}, 32'd1);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("lw_addr1", {16'd0, imem_addr}, 32'd0);
    @(negedge clk); redir_valid = 1'b1; redir_addr = 16'h0500; #1;
    check("lw_addr", {16'd0, imem_addr}, 32'h300);
`ifdef IFU_PERF_CNT_EN
    check("pc_fetch",  {16'd0, fetch_cnt}, 32'd4);
    check("pc_squash", {16'd0, squash_cnt}, 32'd4);
`endif

    // reset while in SQUASH
    @(negedge clk); redir_valid = 1'b0; #1;
    check("rs_req_pre",  {31'd0, imem_req}, 32'd1);
    check("rs_addr_pre", {16'd0, imem_addr}, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    check("rs_req",   {31'd0, imem_req}, 32'd0);
    check("rs_valid", {31'd0, ir_valid}, 32'd0);
    check("rs_addr",  {16'd0, imem_addr}, 32'd0);
    check("rs_instr", ir_instr, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("rs_fetch_cnt",  {16'd0, fetch_cnt}, 32'd0);
    check("rs_squash_cnt", {16'd0, squash_cnt}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1; lat = 0;
    @(negedge clk); #1;
    check("rr_req",  {31'd0, imem_req}, 32'd1);
    check("rr_addr", {16'd0, imem_addr}, 32'd0);
    @(negedge clk); #1;
    check("rr_valid", {31'd0, ir_valid}, 32'd1);
    check("rr_irpc",  {16'd0, ir_pc}, 32'd0);
    check("rr_instr", ir_instr, 32'h2000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
